instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Instruction-side front end for mipscpu: PC register, instruction memory and branch/jump circuit.
//   Fetches a word, drives it on instrword, pulses newinstr, then waits a fixed execute window.
//   At the end of the window it computes the next PC from the opcode and the CPU's ALU zero flag.
// PARAMETERS
//   IMEM_DEPTH   128        instruction memory depth in 32-bit words (word index = pc[8:2])
//   EXEC_CYCLES  4          cycles the CPU control FSM needs per instruction (>=1)
//   RESET_PC     32'h0      PC value loaded on reset and on restart
// PORTS
//   clock     in   1   system clock, all state on rising edge
//   reset     in   1   asynchronous, active-low reset
//   start     in   1   begin/restart execution (level sampled in IDLE/HALT)
//   loaden    in   1   program-load write strobe (honoured only in IDLE/HALT)
//   loadaddr  in   7   program-load word address
//   loaddata  in   32  program-load word
//   aluzero   in   1   ALU result==0 from CPU, valid in last EXECUTE cycle
//   instrword out  32  current instruction to mipscpu
//   newinstr  out  1   one-cycle pulse: instrword is a new instruction
//   pc        out  32  byte address of the current instruction
//   running   out  1   high in FETCH/ISSUE/EXECUTE/UPDATE
//   halted    out  1   high in HALT
//   fault     out  1   set on PC out of range or misaligned; cleared by restart
// BEHAVIOUR
//   Reset (async, reset==0): state=IDLE, pc=RESET_PC, instrword=0, newinstr=0, fault=0, cnt=0; imem not cleared.
//   States: IDLE -> FETCH -> ISSUE -> EXECUTE -> UPDATE -> FETCH | HALT.
//   IDLE: loaden writes imem[loadaddr]<=loaddata; start=1 -> FETCH (start wins over same-cycle loaden; load still done).
//   FETCH:
//   - If pc[1:0]!=0 or pc[31:2]>=IMEM_DEPTH: fault<=1 -> HALT.
//   - Else instrword<=imem[pc[8:2]].
//   - If fetched opcode [31:26]==6'h3F (halt): -> HALT with no newinstr, pc unchanged.
//   - Otherwise -> ISSUE.
//   ISSUE: newinstr=1 for exactly this cycle; cnt<=EXEC_CYCLES-1; -> EXECUTE.
//   EXECUTE: instrword held stable; cnt decrements; at cnt==0 sample aluzero into zreg -> UPDATE.
//   UPDATE: pc4=pc+4 (32-bit, wraps modulo 2^32); imm=sign-extended [15:0]; -> FETCH.
//   - opcode 6'h04 (beq) and zreg=1: pc<=pc4+(imm<<2).
//   - opcode 6'h02 (j): pc<=(pc4[31:28], [25:0], 2'b00).
//   - else pc<=pc4.
//   Range check of the new pc happens at the next FETCH, not in UPDATE.
//   HALT: loaden writes imem; start=1 -> pc<=RESET_PC, fault<=0 -> FETCH.
//   start/loaden in FETCH..UPDATE ignored; imem is not writable while running.
//   Per-instruction latency: EXEC_CYCLES+3 cycles from FETCH to next FETCH.
//   Reset asserted mid-instruction aborts immediately; newinstr drops the same instant.
//   running/halted decode combinationally from state; newinstr is registered (glitch-free).
// CONFIGURATION
//   BNE_EN defined: opcode 6'h05 (bne) is also decoded in UPDATE; taken when zreg=0, same target math as beq.
//   BNE_EN undefined: opcode 6'h05 is treated as non-branch, pc<=pc4.
// TESTING
//   Load [0]=add, [1]=sub, [2]=FC000000; start ->
//     newinstr pulses at pc=0 and pc=4 only; halted=1 with pc=8; pulses EXEC_CYCLES+3 apart.
//   beq at pc=0x10, imm=16'hFFFC, aluzero=1 -> next pc=0x04; with aluzero=0 -> next pc=0x14.
//   j target 26'h10 at pc=0x20 -> next pc=0x40; j to word 200 -> fault=1, halted=1, no newinstr.
//   Assert reset low during EXECUTE ->
//     state IDLE, newinstr=0, pc=0 immediately; imem contents preserved; start re-runs from pc 0.
//   loaden during EXECUTE to addr 3 -> imem[3] unchanged (read back via a later fetch).
//   start held high in HALT -> restart, fault cleared.
//   BNE_EN: bne imm=2 at pc=0, aluzero=0 -> pc=0x0C.
//   Without BNE_EN: same stimulus -> pc=0x04.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - control, program-load and instruction-issue bundle of instr_fetch_unit
interface instr_fetch_unit_if;
  logic        start;
  logic        loaden;
  logic [6:0]  loadaddr;
  logic [31:0] loaddata;
  logic        aluzero;
  logic [31:0] instrword;
  logic        newinstr;
  logic [31:0] pc;
  logic        running;
  logic        halted;
  logic        fault;

  modport master (
    output start, loaden, loadaddr, loaddata, aluzero,
    input  instrword, newinstr, pc, running, halted, fault
  );

  modport slave (
    input  start, loaden, loadaddr, loaddata, aluzero,
    output instrword, newinstr, pc, running, halted, fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register, instruction memory and beq/j next-PC logic for mipscpu
// Optional bne decode is enabled by defining BNE_EN.
module instr_fetch_unit #(
  parameter int          IMEM_DEPTH  = 128,
  parameter int          EXEC_CYCLES = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic             clock,
  input  logic             reset,
  instr_fetch_unit_if.slave bus
);

  localparam int          AW      = $clog2(IMEM_DEPTH);
  localparam int          CW      = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_UPDATE  = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_HALT = 6'h3F;

  logic [2:0]    state;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic          newinstr_q;
  logic          fault_q;
  logic          zreg;
  logic [CW-1:0] cnt;

  logic [31:0] imem [IMEM_DEPTH];

  logic        load_ok;
  logic        fetch_ok;
  logic [31:0] fetch_word;
  logic [5:0]  opcode;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic        take_br;
  logic [31:0] next_pc;

  assign load_ok    = bus.loaden && (state == S_IDLE || state == S_HALT);
  assign fetch_ok   = (pc_q[1:0] == 2'b00) && (pc_q[31:2] < DEPTH_W);
  assign fetch_word = imem[pc_q[AW+1:2]];
  assign opcode     = instr_q[31:26];

  // Memory has no reset so a program survives a mid-run reset.
  always_ff @(posedge clock) begin
    if (load_ok && reset) begin
      imem[bus.loadaddr[AW-1:0]] <= bus.loaddata;
    end
  end

  assign pc4    = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    take_br = (opcode == OP_BEQ) && zreg;
`ifdef BNE_EN
    if ((opcode == OP_BNE) && !zreg) begin
      take_br = 1'b1;
    end
`endif
  end

  always_comb begin
    next_pc = pc4;
    if (take_br) begin
      next_pc = pc4 + br_off;
    end else if (opcode == OP_J) begin
      next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      newinstr_q <= 1'b0;
      fault_q    <= 1'b0;
      zreg       <= 1'b0;
      cnt        <= '0;
    end else begin
      newinstr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!fetch_ok) begin
            fault_q <= 1'b1;
            state   <= S_HALT;
          end else begin
            instr_q <= fetch_word;
            if (fetch_word[31:26] == OP_HALT) begin
              state <= S_HALT;
            end else begin
              // Registered so the pulse lines up exactly with the ISSUE cycle.
              newinstr_q <= 1'b1;
              state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= CW'(EXEC_CYCLES - 1);
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (cnt == '0) begin
            zreg  <= bus.aluzero;
            state <= S_UPDATE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_UPDATE: begin
          pc_q  <= next_pc;
          state <= S_FETCH;
        end
        S_HALT: begin
          if (bus.start) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            state   <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.instrword = instr_q;
  assign bus.newinstr  = newinstr_q;
  assign bus.pc        = pc_q;
  assign bus.fault     = fault_q;
  assign bus.running   = (state == S_FETCH) || (state == S_ISSUE) ||
                         (state == S_EXECUTE) || (state == S_UPDATE);
  assign bus.halted    = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit (bne expectations follow BNE_EN)
module tb_instr_fetch_unit;
  localparam int EXEC = 4;

  logic clock;
  logic reset;
  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(.IMEM_DEPTH(128), .EXEC_CYCLES(EXEC), .RESET_PC(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int   pulse_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t e_mon;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && ifc.newinstr === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_newinstr", 32'(ifc.newinstr), 32'd0);
      end else begin
        e_mon = sb.pop_front();
        check("issue_pc", ifc.pc, e_mon.pc);
        check("issue_word", ifc.instrword, e_mon.word);
      end
    end
  end

  task automatic push(input logic [31:0] p, input logic [31:0] w);
    exp_t e;
    e.pc = p;
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic load(input logic [6:0] a, input logic [31:0] d);
    @(negedge clock);
    ifc.loaden = 1'b1;
    ifc.loadaddr = a;
    ifc.loaddata = d;
    @(negedge clock);
    ifc.loaden = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    ifc.start = 1'b1;
    @(negedge clock);
    ifc.start = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (ifc.halted === 1'b1) break;
      @(negedge clock);
    end
    check(tag, 32'(ifc.halted), 32'd1);
  endtask

  task automatic wait_newinstr();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ifc.newinstr === 1'b1) break;
    end
    check("wait_newinstr", 32'(ifc.newinstr), 32'd1);
  endtask

  task automatic run_program(input string tag, input logic [31:0] pc_end, input logic fault_end);
    pulse_start();
    wait_halted({tag, "_halted"});
    check({tag, "_pc"}, ifc.pc, pc_end);
    check({tag, "_fault"}, 32'(ifc.fault), 32'(fault_end));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  localparam logic [31:0] W_ADD  = 32'h00221820;
  localparam logic [31:0] W_SUB  = 32'h00221822;
  localparam logic [31:0] W_HALT = 32'hFC000000;

  initial begin
    reset = 1'b0;
    ifc.start = 1'b0;
    ifc.loaden = 1'b0;
    ifc.loadaddr = '0;
    ifc.loaddata = '0;
    ifc.aluzero = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_pc", ifc.pc, 32'h0);
    check("rst_instrword", ifc.instrword, 32'h0);
    check("rst_newinstr", 32'(ifc.newinstr), 32'd0);
    check("rst_fault", 32'(ifc.fault), 32'd0);
    check("rst_running", 32'(ifc.running), 32'd0);
    check("rst_halted", 32'(ifc.halted), 32'd0);
    reset = 1'b1;

    // add, sub, halt: two issues EXEC+3 cycles apart, halt at pc 8
    load(7'd0, W_ADD);
    load(7'd1, W_SUB);
    load(7'd2, W_HALT);
    check("idle_running", 32'(ifc.running), 32'd0);
    pulse_cyc.delete();
    push(32'h0, W_ADD);
    push(32'h4, W_SUB);
    run_program("basic", 32'h8, 1'b0);
    check("basic_pulses", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2)
      check("basic_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(EXEC + 3));

    // j to 0x10, beq imm=-4: taken -> 0x04, not taken -> 0x14
    load(7'd0, 32'h08000004);
    load(7'd1, W_HALT);
    load(7'd4, 32'h1000FFFC);
    load(7'd5, W_HALT);
    ifc.aluzero = 1'b1;
    push(32'h0, 32'h08000004);
    push(32'h10, 32'h1000FFFC);
    run_program("beq_taken", 32'h4, 1'b0);
    ifc.aluzero = 1'b0;
    push(32'h0, 32'h08000004);
    push(32'h10, 32'h1000FFFC);
    run_program("beq_not_taken", 32'h14, 1'b0);

    // j chain 0 -> 0x20 -> 0x40
    load(7'd0, 32'h08000008);
    load(7'd8, 32'h08000010);
    load(7'd16, W_HALT);
    push(32'h0, 32'h08000008);
    push(32'h20, 32'h08000010);
    run_program("jump", 32'h40, 1'b0);

    // j to word 200 faults at the following fetch
    load(7'd0, 32'h080000C8);
    push(32'h0, 32'h080000C8);
    run_program("jump_oob", 32'h320, 1'b1);

    // start held in HALT restarts and clears fault
    load(7'd0, W_HALT);
    @(negedge clock);
    ifc.start = 1'b1;
    @(negedge clock);
    check("restart_running", 32'(ifc.running), 32'd1);
    check("restart_fault", 32'(ifc.fault), 32'd0);
    check("restart_pc", ifc.pc, 32'h0);
    ifc.start = 1'b0;
    wait_halted("restart_halted");
    check("restart_fault_end", 32'(ifc.fault), 32'd0);

    // loaden while running is ignored
    load(7'd0, 32'h0);
    load(7'd1, 32'h0);
    load(7'd2, 32'h0);
    load(7'd3, 32'h00000033);
    load(7'd4, W_HALT);
    push(32'h0, 32'h0);
    push(32'h4, 32'h0);
    push(32'h8, 32'h0);
    push(32'hC, 32'h00000033);
    pulse_start();
    wait_newinstr();
    @(negedge clock);
    ifc.loaden = 1'b1;
    ifc.loadaddr = 7'd3;
    ifc.loaddata = W_HALT;
    @(negedge clock);
    ifc.loaden = 1'b0;
    wait_halted("noload_halted");
    check("noload_pc", ifc.pc, 32'h10);
    check("noload_sb_empty", 32'(sb.size()), 32'd0);

    // async reset in EXECUTE aborts at once, program is kept
    push(32'h0, 32'h0);
    pulse_start();
    wait_newinstr();
    @(negedge clock);
    check("exec_running", 32'(ifc.running), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_newinstr", 32'(ifc.newinstr), 32'd0);
    check("midrst_pc", ifc.pc, 32'h0);
    check("midrst_running", 32'(ifc.running), 32'd0);
    check("midrst_halted", 32'(ifc.halted), 32'd0);
    check("midrst_instrword", ifc.instrword, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    push(32'h0, 32'h0);
    push(32'h4, 32'h0);
    push(32'h8, 32'h0);
    push(32'hC, 32'h00000033);
    run_program("rerun", 32'h10, 1'b0);

    // bne imm=2 with aluzero=0
    load(7'd0, 32'h14000002);
    load(7'd1, W_HALT);
    load(7'd3, W_HALT);
    ifc.aluzero = 1'b0;
    push(32'h0, 32'h14000002);
`ifdef BNE_EN
    run_program("bne", 32'hC, 1'b0);
`else
    run_program("bne", 32'h4, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
